// File: rtl/dram_reader_if.sv
// Signal bundle for dram_reader: AXI3 read address/data channels, job config handshake
// and the 64-bit output stream.
interface dram_reader_if;
    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [3:0]  M_AXI_ARLEN;
    logic [1:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic [63:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RLAST;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;
    logic        CONFIG_VALID;
    logic        CONFIG_READY;
    logic [31:0] CONFIG_START_ADDR;
    logic [31:0] CONFIG_NBYTES;
    logic [63:0] DATA;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic        ERROR;

    modport master (
        output M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
        output M_AXI_RREADY, CONFIG_READY, DATA, DATA_VALID, ERROR,
        input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        input  CONFIG_VALID, CONFIG_START_ADDR, CONFIG_NBYTES, DATA_READY
    );

    modport slave (
        input  M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
        input  M_AXI_RREADY, CONFIG_READY, DATA, DATA_VALID, ERROR,
        output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        output CONFIG_VALID, CONFIG_START_ADDR, CONFIG_NBYTES, DATA_READY
    );
endinterface

// File: rtl/dram_reader.sv
// AXI3 read master: streams a contiguous DRAM region as fixed 16-beat INCR bursts into a
// show-ahead FIFO; burst issue is credit-limited so RREADY never drops for lack of space.
module dram_reader #(
    parameter int FIFO_LOG2 = 7
) (
    input  logic          ACLK,
    input  logic          ARESETN,
    dram_reader_if.master bus
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int RW    = FIFO_LOG2 + 2;

    typedef enum logic {A_IDLE, A_REQ} a_state_t;
    typedef enum logic {R_IDLE, R_RUN} r_state_t;

    a_state_t             a_state;
    r_state_t             r_state;
    logic [31:0]          araddr;
    logic                 arvalid;
    logic [24:0]          a_count;
    logic [28:0]          r_count;
    logic [3:0]           beat_idx;
    logic                 rready;
    logic                 error;
    logic [FIFO_LOG2:0]   reserved;
    logic [FIFO_LOG2:0]   fifo_count;
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic [63:0]          mem [DEPTH];

    logic          cfg_ready;
    logic          cfg_fire;
    logic          job_nonzero;
    logic          ar_fire;
    logic          r_fire;
    logic          pop;
    logic [RW-1:0] reserved_next;
    logic          credit_next;
    logic          unused_cfg_bits;

    assign cfg_ready   = (a_state == A_IDLE) && (r_state == R_IDLE) && (fifo_count == '0);
    assign cfg_fire    = bus.CONFIG_VALID && cfg_ready;
    assign job_nonzero = |bus.CONFIG_NBYTES[31:7];
    assign ar_fire     = arvalid && bus.M_AXI_ARREADY;
    assign r_fire      = rready && bus.M_AXI_RVALID;
    assign pop         = (fifo_count != '0) && bus.DATA_READY;

    assign unused_cfg_bits = ^{bus.CONFIG_START_ADDR[6:0], bus.CONFIG_NBYTES[6:0]};

    // reserved = FIFO occupancy + beats requested but not yet returned. ARVALID is registered,
    // so credit is judged on next cycle's reservation to keep it valid once raised.
    always_comb begin
        // NOTE: default assignment first so every path assigns it and no latch is inferred.
        reserved_next = RW'(reserved);
        if (ar_fire) reserved_next = reserved_next + RW'(16);
        if (pop)     reserved_next = reserved_next - RW'(1);
        credit_next = (reserved_next + RW'(16)) <= RW'(DEPTH);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            a_state  <= A_IDLE;
            arvalid  <= 1'b0;
            araddr   <= '0;
            a_count  <= '0;
            reserved <= '0;
        end else begin
            reserved <= reserved_next[FIFO_LOG2:0];
            case (a_state)
                A_IDLE: begin
                    if (cfg_fire) begin
                        araddr  <= {bus.CONFIG_START_ADDR[31:7], 7'b0};
                        a_count <= bus.CONFIG_NBYTES[31:7];
                        if (job_nonzero) begin
                            a_state <= A_REQ;
                            arvalid <= credit_next;
                        end
                    end
                end
                A_REQ: begin
                    if (ar_fire) begin
                        araddr  <= araddr + 32'd128;
                        a_count <= a_count - 25'd1;
                    end
                    if (ar_fire && a_count == 25'd1) begin
                        a_state <= A_IDLE;
                        arvalid <= 1'b0;
                    end else if (!arvalid || ar_fire) begin
                        arvalid <= credit_next;
                    end
                end
                default: a_state <= A_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state    <= R_IDLE;
            rready     <= 1'b0;
            r_count    <= '0;
            beat_idx   <= '0;
            error      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (cfg_fire) begin
                        error    <= 1'b0;
                        r_count  <= {bus.CONFIG_NBYTES[31:7], 4'b0};
                        beat_idx <= '0;
                        if (job_nonzero) begin
                            r_state <= R_RUN;
                            rready  <= 1'b1;
                        end
                    end
                end
                R_RUN: begin
                    if (r_fire) begin
                        r_count  <= r_count - 29'd1;
                        beat_idx <= beat_idx + 4'd1;
                        // Bad beats are still stored; the error only flags the job.
                        if (bus.M_AXI_RRESP != 2'b00 || bus.M_AXI_RLAST != (beat_idx == 4'hF))
                            error <= 1'b1;
                        if (r_count == 29'd1) begin
                            r_state <= R_IDLE;
                            rready  <= 1'b0;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase

            if (r_fire) wr_ptr <= wr_ptr + FIFO_LOG2'(1);
            if (pop)    rd_ptr <= rd_ptr + FIFO_LOG2'(1);
            case ({r_fire, pop})
                2'b10:   fifo_count <= fifo_count + (FIFO_LOG2 + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (FIFO_LOG2 + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: the storage array is not reset; occupancy and pointers alone define valid contents.
    always_ff @(posedge ACLK) begin
        if (r_fire) mem[wr_ptr] <= bus.M_AXI_RDATA;
    end

    assign bus.M_AXI_ARADDR  = araddr;
    assign bus.M_AXI_ARVALID = arvalid;
    assign bus.M_AXI_ARLEN   = 4'b1111;
    assign bus.M_AXI_ARSIZE  = 2'b11;
    assign bus.M_AXI_ARBURST = 2'b01;
    assign bus.M_AXI_RREADY  = rready;
    assign bus.CONFIG_READY  = cfg_ready;
    assign bus.DATA          = mem[rd_ptr];
    assign bus.DATA_VALID    = (fifo_count != '0);
    assign bus.ERROR         = error;
endmodule

// File: tb/tb_dram_reader.sv
// Self-checking bench for dram_reader: AXI slave model with throttling and fault injection,
// a data scoreboard and an expected-address queue.
`timescale 1ns/1ps
module tb_dram_reader;
    localparam int FIFO_LOG2 = 7;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;

    dram_reader_if bus();

    dram_reader #(.FIFO_LOG2(FIFO_LOG2)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus.master)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad = 0;

    logic [63:0] sb[$];
    logic [31:0] ar_exp[$];

    int          ar_rate = 100;
    int          r_rate = 100;
    int          d_rate = 100;
    logic [31:0] data_salt = '0;
    int          rresp_err_at = -1;
    int          rlast_bad_at = -1;
    bit          mon_en = 1'b0;

    int r_pending = 0;
    int beat_pos = 0;
    int beat_seq = 0;
    int ar_seen = 0;
    int beats_acc = 0;
    int pops = 0;

    logic        s_arvalid;
    logic [31:0] s_araddr;
    logic [3:0]  s_arlen;
    logic [1:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_rready;
    logic        s_dvalid;
    logic [63:0] s_data;

    function automatic bit roll(input int rate);
        return int'($urandom_range(99)) < rate;
    endfunction

    // AXI slave, output sink and scoreboard; handshakes are resolved at the negedge after the edge.
    initial begin : bus_model
        bit          ar_fire;
        bit          r_fire;
        bit          pop;
        logic [31:0] exp_a;
        logic [63:0] exp_d;
        forever begin
            @(negedge ACLK);
            r_fire = 1'b0;
            if (!mon_en) begin
                r_pending = 0;
                beat_pos = 0;
                bus.M_AXI_ARREADY = 1'b0;
                bus.M_AXI_RVALID = 1'b0;
                bus.M_AXI_RLAST = 1'b0;
                bus.M_AXI_RRESP = 2'b00;
                bus.M_AXI_RDATA = '0;
                bus.DATA_READY = 1'b0;
            end else begin
                ar_fire = s_arvalid && bus.M_AXI_ARREADY;
                r_fire = s_rready && bus.M_AXI_RVALID;
                pop = s_dvalid && bus.DATA_READY;
                if (ar_fire) begin
                    ar_seen++;
                    total++;
                    if (ar_exp.size() == 0) begin
                        bad++;
                        $display("FAIL ar_unexpected: ARADDR=%h, no AR expected", s_araddr);
                    end else begin
                        exp_a = ar_exp.pop_front();
                        if (s_araddr !== exp_a) begin
                            bad++;
                            $display("FAIL ar_addr: ARADDR=%h, expected %h", s_araddr, exp_a);
                        end
                    end
                    total++;
                    if ({s_arlen, s_arsize, s_arburst} !== {4'hF, 2'b11, 2'b01}) begin
                        bad++;
                        $display("FAIL ar_attr: LEN/SIZE/BURST=%h/%h/%h, expected f/3/1",
                                 s_arlen, s_arsize, s_arburst);
                    end
                    r_pending++;
                end else if (s_arvalid) begin
                    total++;
                    if (bus.M_AXI_ARVALID !== 1'b1 || bus.M_AXI_ARADDR !== s_araddr) begin
                        bad++;
                        $display("FAIL ar_hold: ARVALID=%b ARADDR=%h, expected 1 %h",
                                 bus.M_AXI_ARVALID, bus.M_AXI_ARADDR, s_araddr);
                    end
                end
                if (r_fire) begin
                    sb.push_back(bus.M_AXI_RDATA);
                    beats_acc++;
                    beat_seq++;
                    beat_pos++;
                    if (beat_pos == 16) begin
                        beat_pos = 0;
                        r_pending--;
                    end
                end
                if (pop) begin
                    pops++;
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL data_underflow: DATA=%h popped, expected no word", s_data);
                    end else begin
                        exp_d = sb.pop_front();
                        if (s_data !== exp_d) begin
                            bad++;
                            $display("FAIL data_order: DATA=%h, expected %h", s_data, exp_d);
                        end
                    end
                end else if (s_dvalid) begin
                    total++;
                    if (bus.DATA_VALID !== 1'b1 || bus.DATA !== s_data) begin
                        bad++;
                        $display("FAIL data_hold: DATA_VALID=%b DATA=%h, expected 1 %h",
                                 bus.DATA_VALID, bus.DATA, s_data);
                    end
                end
            end

            s_arvalid = bus.M_AXI_ARVALID;
            s_araddr  = bus.M_AXI_ARADDR;
            s_arlen   = bus.M_AXI_ARLEN;
            s_arsize  = bus.M_AXI_ARSIZE;
            s_arburst = bus.M_AXI_ARBURST;
            s_rready  = bus.M_AXI_RREADY;
            s_dvalid  = bus.DATA_VALID;
            s_data    = bus.DATA;

            if (mon_en) begin
                if (r_pending > 0) begin
                    total++;
                    if (s_rready !== 1'b1) begin
                        bad++;
                        $display("FAIL rready_drop: RREADY=%b with %0d bursts owed, expected 1",
                                 s_rready, r_pending);
                    end
                end
                bus.M_AXI_ARREADY = roll(ar_rate);
                if (!(bus.M_AXI_RVALID && !r_fire)) begin
                    if (r_pending > 0 && roll(r_rate)) begin
                        bus.M_AXI_RVALID = 1'b1;
                        bus.M_AXI_RDATA = {data_salt, 32'(beat_seq)};
                        bus.M_AXI_RLAST = (beat_pos == 15) ^ (beat_seq == rlast_bad_at);
                        bus.M_AXI_RRESP = (beat_seq == rresp_err_at) ? 2'b10 : 2'b00;
                    end else begin
                        bus.M_AXI_RVALID = 1'b0;
                    end
                end
                bus.DATA_READY = roll(d_rate);
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #2;
    endtask

    task automatic start_job(input logic [31:0] addr, input logic [31:0] nbytes);
        int          waited;
        logic [31:0] base;
        waited = 0;
        while (bus.CONFIG_READY !== 1'b1 && waited < 2000) begin
            tick();
            waited++;
        end
        total++;
        if (bus.CONFIG_READY !== 1'b1) begin
            bad++;
            $display("FAIL cfg_ready_wait: CONFIG_READY=%b, expected 1", bus.CONFIG_READY);
        end
        base = {addr[31:7], 7'b0};
        for (int k = 0; k < int'(nbytes >> 7); k++) ar_exp.push_back(base + 32'(k) * 32'd128);
        beat_seq = 0;
        bus.CONFIG_START_ADDR = addr;
        bus.CONFIG_NBYTES = nbytes;
        bus.CONFIG_VALID = 1'b1;
        tick();
        bus.CONFIG_VALID = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int c;
        c = 0;
        while (!(bus.CONFIG_READY === 1'b1 && sb.size() == 0 && ar_exp.size() == 0) && c < bound) begin
            tick();
            c++;
        end
        total++;
        if (c >= bound) begin
            bad++;
            $display("FAIL job_timeout: CONFIG_READY=%b words_left=%0d ars_left=%0d, expected 1 0 0",
                     bus.CONFIG_READY, sb.size(), ar_exp.size());
        end
    endtask

    task automatic test_reset();
        mon_en = 1'b0;
        ARESETN = 1'b0;
        bus.CONFIG_VALID = 1'b0;
        bus.CONFIG_START_ADDR = '0;
        bus.CONFIG_NBYTES = '0;
        bus.M_AXI_ARREADY = 1'b0;
        bus.M_AXI_RVALID = 1'b0;
        bus.M_AXI_RLAST = 1'b0;
        bus.M_AXI_RRESP = 2'b00;
        bus.M_AXI_RDATA = '0;
        bus.DATA_READY = 1'b0;
        repeat (3) tick();
        total++;
        if ({bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.DATA_VALID, bus.ERROR, bus.M_AXI_ARADDR} !== 36'h0) begin
            bad++;
            $display("FAIL reset_outputs: ARVALID=%b RREADY=%b DATA_VALID=%b ERROR=%b ARADDR=%h, expected all 0",
                     bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.DATA_VALID, bus.ERROR, bus.M_AXI_ARADDR);
        end
        ARESETN = 1'b1;
        tick();
        total++;
        if (bus.CONFIG_READY !== 1'b1) begin
            bad++;
            $display("FAIL reset_cfg_ready: CONFIG_READY=%b, expected 1", bus.CONFIG_READY);
        end
        mon_en = 1'b1;
        tick();
    endtask

    task automatic test_single_burst();
        int a0;
        int p0;
        ar_rate = 100; r_rate = 100; d_rate = 100; data_salt = '0;
        a0 = ar_seen;
        p0 = pops;
        start_job(32'h1000_0040, 32'd128);
        wait_done(500);
        total++;
        if (ar_seen - a0 !== 1) begin
            bad++;
            $display("FAIL single_ar_count: %0d ARs, expected 1", ar_seen - a0);
        end
        total++;
        if (pops - p0 !== 16) begin
            bad++;
            $display("FAIL single_words: %0d words, expected 16", pops - p0);
        end
        total++;
        if (bus.ERROR !== 1'b0) begin
            bad++;
            $display("FAIL single_error: ERROR=%b, expected 0", bus.ERROR);
        end
        total++;
        if (bus.CONFIG_READY !== 1'b1) begin
            bad++;
            $display("FAIL single_cfg_ready: CONFIG_READY=%b, expected 1", bus.CONFIG_READY);
        end
    endtask

    task automatic test_backpressure();
        int a0;
        int b0;
        int p0;
        ar_rate = 100; r_rate = 100; d_rate = 0; data_salt = 32'h0000_BEEF;
        a0 = ar_seen;
        b0 = beats_acc;
        p0 = pops;
        start_job(32'h2000_0000, 32'd2048);
        repeat (400) tick();
        total++;
        if (ar_seen - a0 !== 8) begin
            bad++;
            $display("FAIL credit_ar_count: %0d ARs while stalled, expected 8", ar_seen - a0);
        end
        total++;
        if (beats_acc - b0 !== 128) begin
            bad++;
            $display("FAIL credit_beats: %0d beats while stalled, expected 128", beats_acc - b0);
        end
        total++;
        if (bus.M_AXI_ARVALID !== 1'b0) begin
            bad++;
            $display("FAIL credit_arvalid: ARVALID=%b while FIFO full, expected 0", bus.M_AXI_ARVALID);
        end
        d_rate = 100;
        wait_done(2000);
        total++;
        if (ar_seen - a0 !== 16 || pops - p0 !== 256) begin
            bad++;
            $display("FAIL drain_totals: %0d ARs %0d words, expected 16 256", ar_seen - a0, pops - p0);
        end
    endtask

    task automatic test_random_throttle();
        int a0;
        int p0;
        ar_rate = 60; r_rate = 70; d_rate = 60; data_salt = 32'hA5A5_0000;
        a0 = ar_seen;
        p0 = pops;
        start_job(32'hFFFF_8025, 32'd65536);
        wait_done(40000);
        total++;
        if (ar_seen - a0 !== 512 || pops - p0 !== 8192) begin
            bad++;
            $display("FAIL random_totals: %0d ARs %0d words, expected 512 8192", ar_seen - a0, pops - p0);
        end
        total++;
        if (bus.ERROR !== 1'b0) begin
            bad++;
            $display("FAIL random_error: ERROR=%b, expected 0", bus.ERROR);
        end
        ar_rate = 100; r_rate = 100; d_rate = 100;
    endtask

    task automatic test_error_cases();
        int p0;
        data_salt = 32'h0E0E_0000;
        rresp_err_at = 5;
        start_job(32'h3000_0000, 32'd128);
        wait_done(500);
        total++;
        if (bus.ERROR !== 1'b1) begin
            bad++;
            $display("FAIL rresp_error: ERROR=%b at job end, expected 1", bus.ERROR);
        end
        rresp_err_at = -1;
        rlast_bad_at = 7;
        p0 = pops;
        start_job(32'h3000_0080, 32'd128);
        total++;
        if (bus.ERROR !== 1'b0) begin
            bad++;
            $display("FAIL error_clear: ERROR=%b after accept, expected 0", bus.ERROR);
        end
        wait_done(500);
        total++;
        if (bus.ERROR !== 1'b1) begin
            bad++;
            $display("FAIL rlast_error: ERROR=%b at job end, expected 1", bus.ERROR);
        end
        total++;
        if (pops - p0 !== 16) begin
            bad++;
            $display("FAIL rlast_words: %0d words, expected 16", pops - p0);
        end
        rlast_bad_at = -1;
    endtask

    task automatic test_zero_length();
        int a0;
        a0 = ar_seen;
        start_job(32'h4000_0000, 32'd100);
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (bus.CONFIG_READY !== 1'b1 || bus.M_AXI_ARVALID !== 1'b0) begin
                bad++;
                $display("FAIL zero_len_idle: CONFIG_READY=%b ARVALID=%b, expected 1 0",
                         bus.CONFIG_READY, bus.M_AXI_ARVALID);
            end
        end
        total++;
        if (ar_seen - a0 !== 0) begin
            bad++;
            $display("FAIL zero_len_ar: %0d ARs, expected 0", ar_seen - a0);
        end
    endtask

    task automatic test_reset_mid_job();
        int p0;
        d_rate = 0; data_salt = 32'h5555_0000; rresp_err_at = 3;
        start_job(32'h5000_0000, 32'd2048);
        repeat (30) tick();
        total++;
        if (bus.ERROR !== 1'b1 || bus.DATA_VALID !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_state: ERROR=%b DATA_VALID=%b, expected 1 1", bus.ERROR, bus.DATA_VALID);
        end
        mon_en = 1'b0;
        #1;
        ARESETN = 1'b0;
        #1;
        total++;
        if ({bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.DATA_VALID, bus.ERROR, bus.M_AXI_ARADDR} !== 36'h0) begin
            bad++;
            $display("FAIL async_reset: ARVALID=%b RREADY=%b DATA_VALID=%b ERROR=%b ARADDR=%h, expected all 0",
                     bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.DATA_VALID, bus.ERROR, bus.M_AXI_ARADDR);
        end
        sb.delete();
        ar_exp.delete();
        rresp_err_at = -1;
        repeat (3) tick();
        ARESETN = 1'b1;
        tick();
        total++;
        if (bus.CONFIG_READY !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_ready: CONFIG_READY=%b, expected 1", bus.CONFIG_READY);
        end
        mon_en = 1'b1;
        d_rate = 100;
        tick();
        p0 = pops;
        start_job(32'h6000_0000, 32'd128);
        wait_done(500);
        total++;
        if (pops - p0 !== 16) begin
            bad++;
            $display("FAIL post_reset_job: %0d words, expected 16", pops - p0);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_backpressure();
        test_random_throttle();
        test_error_cases();
        test_zero_length();
        test_reset_mid_job();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dram_reader.md
# dram_reader

AXI3 read master that streams a contiguous DRAM region into the accelerator pipeline as 64-bit words, the read-side counterpart of the DRAM writer on the same HP port. Software supplies a start address and byte count via a valid/ready config handshake. The block issues fixed 16-beat INCR bursts, buffers returned beats in an internal FIFO, and presents them on a valid/ready stream. Burst issue is credit-limited so the FIFO never overflows and RREADY never drops for lack of space.

## Interface
- FIFO_LOG2, default 7: log2 of data FIFO depth in 64-bit words. Minimum 4. Default 128 words allows 8 bursts in flight.
- ACLK  in  1  clock; all logic rising-edge.
- ARESETN  in  1  reset, asynchronous, active-low.
- M_AXI_ARADDR  out  32  burst address.
- M_AXI_ARVALID  out  1  / M_AXI_ARREADY  in  1  AR handshake.
- M_AXI_ARLEN  out  4  constant 4'b1111 (16 beats).
- M_AXI_ARSIZE  out  2  constant 2'b11 (8 bytes).
- M_AXI_ARBURST  out  2  constant 2'b01 (INCR).
- M_AXI_RDATA  in  64  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RLAST  in  1  last beat of burst.
- M_AXI_RVALID  in  1  / M_AXI_RREADY  out  1  R handshake.
- CONFIG_VALID  in  1  / CONFIG_READY  out  1  job handshake.
- CONFIG_START_ADDR  in  32  byte address; bits [6:0] forced to 0.
- CONFIG_NBYTES  in  32  byte count; only bits [31:7] are used (whole 128-byte bursts).
- DATA  out  64  head-of-FIFO word.
- DATA_VALID  out  1  / DATA_READY  in  1  output stream handshake.
- ERROR  out  1  sticky error: any RRESP != 0, or RLAST mismatching the beat count. Cleared only by reset or job accept.

## Operation
- Job accept occurs when CONFIG_VALID && CONFIG_READY.
  - CONFIG_READY = address FSM IDLE && read FSM IDLE && FIFO empty.
  - On accept, latch addr = {START[31:7],7'b0}, a_count = NBYTES[31:7], r_count = NBYTES[31:7]×16 beats, and clear ERROR.
  - If NBYTES[31:7] == 0, the job is accepted and discarded: no AR, both FSMs stay IDLE.
- Address FSM, IDLE/REQ:
  - REQ drives ARVALID = (credit_ok).
  - credit_ok = reserved + 16 ≤ 2^FIFO_LOG2, where reserved = FIFO occupancy + beats requested but not yet received.
  - On ARREADY && ARVALID: addr += 128, a_count -= 1, reserved += 16. When a_count reaches 0, go to IDLE.
- Read FSM, IDLE/RUN:
  - RREADY = (state == RUN). Credit reservation guarantees space.
  - Each accepted beat is written to the FIFO and decrements r_count.
  - A 4-bit beat index counts 0..15. RLAST must equal (index == 15); a mismatch sets ERROR, but data is still stored.
  - When r_count reaches 0, go to IDLE.
- FIFO: circular buffer, show-ahead.
  - DATA_VALID = !empty.
  - A pop (DATA_VALID && DATA_READY) releases one credit (reserved -= 1).
  - Simultaneous push and pop leaves occupancy unchanged. Pointers wrap modulo depth.
  - Occupancy counter is FIFO_LOG2+1 bits so that full and empty are distinct.
- Arithmetic: 32-bit address wraps modulo 2^32, with no 4 KB-boundary check (128-aligned bursts never cross one). r_count is 29 bits wide.
- reserved update per cycle = +16·AR_fire − pop, with both applied in the same cycle.

## Timing
- Reset (async assert, synchronous-to-ACLK deassert expected) sets:
  - ARVALID = 0, RREADY = 0, DATA_VALID = 0, ERROR = 0, ARADDR = 0.
  - CONFIG_READY = 1 after the first clock out of reset. Counters and pointers = 0.
- Reset mid-job aborts immediately. In-flight AXI bursts are dropped, so the interconnect must be reset together with this block.
- ARVALID, once asserted, stays high with ARADDR stable until ARREADY. It never deasserts without a handshake.
- Accept-to-first-ARVALID: 1 cycle (registered FSM).
- R beat accepted at edge n → DATA_VALID at edge n+1 with that word on DATA. A pop at edge n exposes the next word at n+1 with no bubble.
- Back-to-back AR issue occurs every cycle while credit_ok and ARREADY hold.
- DATA is stable while DATA_VALID && !DATA_READY.
- CONFIG_READY returns 1 the cycle after the final word is popped.

## Test plan
- Single burst: START=0x1000_0040, NBYTES=128, ARREADY=1, 16 R beats with RDATA=i. Required: one AR with ARADDR=0x1000_0000 and ARLEN=15; DATA yields 0..15 in order; ERROR=0; CONFIG_READY returns high.
- Backpressure / credit limit: FIFO_LOG2=7, NBYTES=2048 (16 bursts), DATA_READY=0. Required: exactly 8 ARs issued and 128 beats accepted, RREADY never drops during a burst, then no further AR. Raising DATA_READY drains data and the remaining 8 bursts issue; the 256 words arrive in order.
- Random throttling: randomize ARREADY, RVALID and DATA_READY over a 64 KB job. Required: scoreboard matches; ARADDR increments by 0x80; no FIFO overflow or underflow.
- Error cases:
  - RRESP=2'b10 on beat 5 sets ERROR, and it stays set through the end of the job.
  - In a separate job, RLAST high on beat 7 sets ERROR; all 16 words are still delivered.
- Zero length and reset mid-job:
  - NBYTES=100 is accepted with no AR and CONFIG_READY stays 1.
  - ARESETN low mid-burst drives all outputs to reset values within the same cycle (asynchronously).
